// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the shared 32-bit multicycle ARM datapath. Contains the
// main sequencing FSM, the ALU decoder, the stored NZCV flag register and the
// condition-code evaluator. Every datapath enable and mux select comes from
// here.
//
// Instructions: LDR/STR (immediate offset), ADD/SUB/AND/ORR/CMP (register or
// immediate operand) and B.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   Cond         instruction[31:28]
//   Op           instruction[27:26]
//   Funct        instruction[25:20]
//   Rd           instruction[15:12]
//   ALUFlags     {N,Z,C,V} produced by the ALU in the current cycle
//   PCWrite      PC register enable
//   AdrSrc       memory address select: 0=PC, 1=ALUOut
//   MemWrite     data memory write enable
//   IRWrite      instruction register enable
//   ResultSrc    result mux: 00=ALUOut, 01=ReadData, 10=ALU result
//   ALUControl   00=ADD, 01=SUB, 10=AND, 11=ORR
//   ALUSrcA      0=RD1, 1=PC
//   ALUSrcB      00=RD2, 01=ImmExt, 10=constant 4
//   ImmSrc       immediate extender format (equals Op)
//   RegWrite     register file write enable
//   RegSrc       bit0 selects R15 as A1 (branch), bit1 selects Rd as A2 (store)
//   Flags        stored {N,Z,C,V}
//
// All outputs are combinational from state, Op, Funct, Rd and the registered
// condition result; none depends combinationally on ALUFlags.
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int FLAG_W  = 4,
  parameter int STATE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [FLAG_W-1:0] ALUFlags,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUControl,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic              RegWrite,
  output logic [1:0]        RegSrc,
  output logic [FLAG_W-1:0] Flags
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } stateType;

  // Data-processing cmd field encodings (Funct[4:1]).
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  stateType          state;
  stateType          nextState;
  logic              condEx;
  logic [FLAG_W-1:0] flagsReg;

  // ALU decoder results.
  logic [1:0] aluOp;
  logic       cmdSupported;
  logic       isCmp;
  logic       updatesCV;
  logic       execState;
  logic       setsFlags;

  // Unmasked enables; rst masks them below.
  logic pcWriteRaw;
  logic memWriteRaw;
  logic irWriteRaw;
  logic regWriteRaw;

  // -------------------------------------------------------------------------
  // ARM condition-code table over stored {N,Z,C,V}.
  // -------------------------------------------------------------------------
  function automatic logic condHolds(input logic [3:0] cond,
                                     input logic [FLAG_W-1:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    unique case (cond)
      4'b0000: condHolds = z;                 // EQ
      4'b0001: condHolds = ~z;                // NE
      4'b0010: condHolds = c;                 // CS
      4'b0011: condHolds = ~c;                // CC
      4'b0100: condHolds = n;                 // MI
      4'b0101: condHolds = ~n;                // PL
      4'b0110: condHolds = v;                 // VS
      4'b0111: condHolds = ~v;                // VC
      4'b1000: condHolds = c & ~z;            // HI
      4'b1001: condHolds = ~c | z;            // LS
      4'b1010: condHolds = (n == v);          // GE
      4'b1011: condHolds = (n != v);          // LT
      4'b1100: condHolds = ~z & (n == v);     // GT
      4'b1101: condHolds = z | (n != v);      // LE
      4'b1110: condHolds = 1'b1;              // AL
      default: condHolds = 1'b0;              // 1111: never executes
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // ALU decoder
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    aluOp        = 2'b00;
    cmdSupported = 1'b1;
    isCmp        = 1'b0;
    updatesCV    = 1'b0;
    unique case (Funct[4:1])
      CMD_ADD: begin aluOp = 2'b00; updatesCV = 1'b1; end
      CMD_SUB: begin aluOp = 2'b01; updatesCV = 1'b1; end
      CMD_AND: aluOp = 2'b10;
      CMD_ORR: aluOp = 2'b11;
      CMD_CMP: begin aluOp = 2'b01; updatesCV = 1'b1; isCmp = 1'b1; end
      default: cmdSupported = 1'b0;
    endcase
  end

  assign execState = (state == EXECR) || (state == EXECI);
  // S-bit or CMP, executed, and a command the ALU actually implements.
  assign setsFlags = execState && condEx && cmdSupported && (Funct[0] || isCmp);

  // -------------------------------------------------------------------------
  // State, condition and flag registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      condEx   <= 1'b0;
      flagsReg <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= nextState;
      // The condition is resolved once per instruction against the flags
      // that were stored before this instruction could touch them.
      if (state == DECODE)
        condEx <= condHolds(Cond, flagsReg);
      if (setsFlags) begin
        flagsReg[3:2] <= ALUFlags[3:2];
        // Logical ops leave carry and overflow untouched.
        if (updatesCV)
          flagsReg[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    nextState = FETCH;
    unique case (state)
      FETCH:  nextState = DECODE;
      DECODE: begin
        unique case (Op)
          2'b01:   nextState = MEMADR;
          2'b00:   nextState = Funct[5] ? EXECI : EXECR;
          2'b10:   nextState = BRANCH;
          default: nextState = FETCH;        // undefined op: abandon
        endcase
      end
      MEMADR: nextState = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  nextState = MEMWB;
      EXECR:  nextState = ALUWB;
      EXECI:  nextState = ALUWB;
      default: nextState = FETCH;            // MEMWB, MEMWR, ALUWB, BRANCH, illegal
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-state outputs
  // -------------------------------------------------------------------------
  always_comb begin
    pcWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUControl  = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    unique case (state)
      FETCH: begin
        irWriteRaw = 1'b1;
        pcWriteRaw = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      DECODE: begin
        // Precompute PC+8 so R15 reads correctly during execute.
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = condEx;
        pcWriteRaw  = condEx && (Rd == 4'hF);
      end
      MEMWR: begin
        AdrSrc      = 1'b1;
        memWriteRaw = condEx;
      end
      EXECR: ALUControl = aluOp;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = aluOp;
      end
      ALUWB: begin
        regWriteRaw = condEx && !isCmp && cmdSupported;
        pcWriteRaw  = condEx && !isCmp && cmdSupported && (Rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pcWriteRaw = condEx;
      end
      default: ;
    endcase
  end

  // State is already FETCH while rst is high, so only the enables need masking.
  assign PCWrite  = pcWriteRaw  & ~rst;
  assign MemWrite = memWriteRaw & ~rst;
  assign IRWrite  = irWriteRaw  & ~rst;
  assign RegWrite = regWriteRaw & ~rst;

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
  assign Flags  = flagsReg;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit that sequences the shared 32-bit ARM datapath over multiple cycles: PC, instruction memory, register file, ALU, data memory and immediate extender.
- Holds the main FSM, the ALU decoder, the NZCV flag register and condition-code evaluation.
- Drives all enables and mux selects, replacing the fixed LDR-only control.
- Supports LDR/STR (immediate offset), data-processing ADD/SUB/AND/ORR/CMP (register or immediate), and B.

Parameters:
- FLAG_W, 4, width of stored flag vector {N,Z,C,V}.
- STATE_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- Cond  input  4  instruction[31:28]
- Op  input  2  instruction[27:26]
- Funct  input  6  instruction[25:20]
- Rd  input  4  instruction[15:12]
- ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register enable
- ResultSrc  output  2  result mux: 00=ALUOut, 01=ReadData, 10=ALU result
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ALUSrcA  output  1  0=RD1, 1=PC
- ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  output  2  equals Op
- RegWrite  output  1  register file write enable
- RegSrc  output  2  bit0=(Op==10) selects R15 as A1; bit1=(Op==01) selects Rd as A2
- Flags  output  4  current stored NZCV

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Any other encoding goes to FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 and Funct[5]=0 -> EXECR; Op=00 and Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR. MEMRD->MEMWB.
  - EXECR/EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
- Latency in cycles: LDR 5, STR 4, data-processing 4, B 3, undefined Op 2.
- Per-state outputs (unlisted outputs 0):
  - FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - EXECR: ALUSrcB=00, decoded op.
  - EXECI: ALUSrcB=01, decoded op.
  - ALUWB: RegWrite=CondEx and not CMP and cmd supported.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx.
- If MEMWB or ALUWB writes Rd==15: PCWrite=CondEx in that cycle as well as RegWrite.
- ALU decoder (EXECR/EXECI only), cmd=Funct[4:1]:
  - 0100 -> ADD; 0010 -> SUB; 0000 -> AND; 1100 -> ORR; 1010 (CMP) -> SUB with no register write.
  - Other cmd: ALUControl=00, no register write, no flag update.
  - In all other states ALUControl=00.
- CondEx is registered on the DECODE edge from Cond and stored Flags using the standard ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1. Cond=1111 gives 0.
- Flags update on the clock edge ending EXECR/EXECI iff CondEx and (Funct[0]=1 or CMP):
  - N and Z always update.
  - C and V update for ADD, SUB and CMP only; AND and ORR preserve C and V.
- Reset (async, any time, including mid-instruction): state=FETCH, Flags=0000, CondEx=0.
  - While rst=1: PCWrite, IRWrite, RegWrite and MemWrite are forced 0; mux selects take FETCH values.
  - First FETCH after deassertion behaves normally.
- All outputs are combinational from state, Op, Funct, Rd and CondEx. No output depends combinationally on ALUFlags.

Test Plan:
- LDR R1,[R2,#8], Cond=1110: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. ALUSrcB=01 in MEMADR. RegWrite=1 only in MEMWB, ResultSrc=01 there. PCWrite=1 only in FETCH.
- STR with Cond=0000 (EQ) and Z=0: 4-cycle sequence completes, MemWrite stays 0 in MEMWR. Repeat with Z=1: MemWrite=1 for exactly one cycle.
- ADDS R3,R1,R2 with ALUFlags=0110 in EXECR: Flags=0110 after that edge, RegWrite=1 in ALUWB. Following ANDS with ALUFlags=1000: Flags=1010 (C/V preserved).
- CMP with ALUFlags=0100: Flags Z=1, ALUControl=01, RegWrite=0 throughout. Next BNE: PCWrite=0 in BRANCH. BEQ instead: PCWrite=1 in BRANCH.
- ADD R15 (Rd=15), immediate form: EXECI then ALUWB with both RegWrite=1 and PCWrite=1.
- Assert rst during MEMRD: state returns to FETCH asynchronously, Flags=0000, all enables 0 while rst high. After release, the next instruction fetches with IRWrite=1.
